// File: rtl/register_file.sv
// register_file: rv32i architectural integer register file.
// 32 x WIDTH registers, x0 hardwired to zero, two combinational read ports,
// one synchronous write port decoded through decoder_5_to_32.
// Optional feature macro: REGISTER_FILE_BYPASS_EN enables write-through
// forwarding from the write port to each read port in the same cycle.

// One-hot write-strobe decoder: out[i] is high when ena is set and in == i.
module decoder_5_to_32 (
  input  logic        ena,
  input  logic [4:0]  in,
  output logic [31:0] out
);

  // Shift a single one into position; all-zero when disabled.
  always_comb begin
    out = '0;
    if (ena) begin
      out = 32'd1 << in;
    end
  end

endmodule

module register_file #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_ena,
  input  logic [4:0]       wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [4:0]       rd_addr0,
  input  logic [4:0]       rd_addr1,
  output logic [WIDTH-1:0] rd_data0,
  output logic [WIDTH-1:0] rd_data1
);

  // Storage exists only for x1..x31; x0 is a constant.
  logic [WIDTH-1:0] regs_reg [1:DEPTH-1];

  // Read view of the whole address space, with slot 0 tied to zero.
  logic [WIDTH-1:0] rf_view [0:DEPTH-1];

  logic [31:0] wr_strobe;

  // Strobe bit 0 addresses x0, which has nothing to write.
  logic unused_strobe0;
  assign unused_strobe0 = wr_strobe[0];

  decoder_5_to_32 u_wr_decoder (
    .ena (wr_ena),
    .in  (wr_addr),
    .out (wr_strobe)
  );

  assign rf_view[0] = '0;

  genvar gi;
  generate
    for (gi = 1; gi < DEPTH; gi++) begin : g_reg
      // Per-register update: reset clears, otherwise load on its strobe.
      always_ff @(posedge clk) begin
        if (rst) begin
          regs_reg[gi] <= '0;
        end else if (wr_strobe[gi]) begin
          regs_reg[gi] <= wr_data;
        end
      end

      assign rf_view[gi] = regs_reg[gi];
    end
  endgenerate

`ifdef REGISTER_FILE_BYPASS_EN
  // Forward the in-flight write when it targets the register being read.
  // A reset cycle or an x0 target never forwards.
  logic wr_live;
  assign wr_live = wr_ena && !rst && (wr_addr != 5'd0);

  // Port reads with write-through forwarding.
  always_comb begin
    rd_data0 = rf_view[rd_addr0];
    rd_data1 = rf_view[rd_addr1];
    if (wr_live && (wr_addr == rd_addr0)) begin
      rd_data0 = wr_data;
    end
    if (wr_live && (wr_addr == rd_addr1)) begin
      rd_data1 = wr_data;
    end
  end
`else
  // Port reads straight from the stored state; new writes show next cycle.
  always_comb begin
    rd_data0 = rf_view[rd_addr0];
    rd_data1 = rf_view[rd_addr1];
  end
`endif

endmodule

// File: tb/tb_register_file.sv
// Directed testbench for register_file: reset, full write/read sweep,
// x0 immutability, reset/write collision, wr_ena gating, back-to-back
// writes and same-cycle read of the write target (build-dependent).
module tb_register_file;

  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic             wr_ena;
  logic [4:0]       wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [4:0]       rd_addr0;
  logic [4:0]       rd_addr1;
  logic [WIDTH-1:0] rd_data0;
  logic [WIDTH-1:0] rd_data1;

  int tests;
  int fails;

  register_file #(.WIDTH(WIDTH), .DEPTH(32)) dut (
    .clk      (clk),
    .rst      (rst),
    .wr_ena   (wr_ena),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr0 (rd_addr0),
    .rd_addr1 (rd_addr1),
    .rd_data0 (rd_data0),
    .rd_data1 (rd_data1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic [4:0]  ra0;
    logic [4:0]  ra1;
    logic [31:0] exp0;
    logic [31:0] exp1;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %08h expected %08h", name, got, exp);
    end else begin
      $display("[TB] ok   %s: %08h", name, got);
    end
  endtask

  // Drive one cycle's inputs just after a rising edge.
  task automatic drive(input logic r, input logic we, input logic [4:0] wa,
                       input logic [31:0] wd, input logic [4:0] a0, input logic [4:0] a1);
    @(posedge clk);
    #1;
    rst = r; wr_ena = we; wr_addr = wa; wr_data = wd;
    rd_addr0 = a0; rd_addr1 = a1;
  endtask

  // Idle-read both ports at every address and compare with expectations.
  task automatic sweep(input string tag, input logic [31:0] base, input logic zero);
    logic [31:0] e;
    for (int a = 0; a < 32; a++) begin
      drive(1'b0, 1'b0, 5'd0, 32'h0, 5'(a), 5'(31 - a));
      @(negedge clk);
      e = (zero || a == 0) ? 32'h0 : base + 32'(a);
      check($sformatf("%s p0 x%0d", tag, a), rd_data0, e);
      e = (zero || (31 - a) == 0) ? 32'h0 : base + 32'(31 - a);
      check($sformatf("%s p1 x%0d", tag, 31 - a), rd_data1, e);
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1; wr_ena = 1'b0; wr_addr = '0; wr_data = '0;
    rd_addr0 = '0; rd_addr1 = '0;

    // Initial reset, then everything reads zero.
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
    sweep("init", 32'h0, 1'b1);

    // Write x5, confirm, then reset clears it and every address.
    drive(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, 5'd0, 5'd0);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    @(negedge clk);
    check("x5 written", rd_data0, 32'hDEADBEEF);
    drive(1'b1, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd5, 5'd5);
    @(negedge clk);
    check("x5 after rst p0", rd_data0, 32'h0);
    check("x5 after rst p1", rd_data1, 32'h0);
    sweep("postrst", 32'h0, 1'b1);

    // Write 0x1000_0000 + i to x1..x31 and sweep both ports.
    for (int i = 1; i < 32; i++) begin
      drive(1'b0, 1'b1, 5'(i), 32'h1000_0000 + 32'(i), 5'd0, 5'd0);
    end
    sweep("all", 32'h1000_0000, 1'b0);

    // Directed vectors: reads compared before the edge on which inputs act.
    vecs[0] = '{1'b0, 1'b1, 5'd0,  32'hFFFFFFFF, 5'd0,  5'd0,  32'h0,         32'h0};
    vecs[1] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd0,  5'd1,  32'h0,         32'h10000001};
    vecs[2] = '{1'b0, 1'b0, 5'd9,  32'h55AA55AA, 5'd9,  5'd9,  32'h10000009,  32'h10000009};
    vecs[3] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd9,  5'd5,  32'h10000009,  32'h10000005};
    vecs[4] = '{1'b1, 1'b1, 5'd3,  32'hABCD0123, 5'd3,  5'd31, 32'h10000003,  32'h1000001F};
    vecs[5] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd3,  5'd31, 32'h0,         32'h0};
    vecs[6] = '{1'b0, 1'b0, 5'd9,  32'h55AA55AA, 5'd9,  5'd0,  32'h0,         32'h0};
    vecs[7] = '{1'b0, 1'b1, 5'd31, 32'hCAFEF00D, 5'd9,  5'd1,  32'h0,         32'h0};
    vecs[8] = '{1'b0, 1'b1, 5'd31, 32'h12345678, 5'd1,  5'd2,  32'h0,         32'h0};
    vecs[9] = '{1'b0, 1'b0, 5'd0,  32'h0,        5'd31, 5'd31, 32'h12345678,  32'h12345678};

    for (int v = 0; v < 10; v++) begin
      drive(vecs[v].rst, vecs[v].we, vecs[v].wa, vecs[v].wd, vecs[v].ra0, vecs[v].ra1);
      @(negedge clk);
      check($sformatf("vec%0d p0", v), rd_data0, vecs[v].exp0);
      check($sformatf("vec%0d p1", v), rd_data1, vecs[v].exp1);
    end

    // Same-cycle read of the write target on x7.
    drive(1'b0, 1'b1, 5'd7, 32'h11111111, 5'd0, 5'd0);
    drive(1'b0, 1'b1, 5'd7, 32'h22222222, 5'd7, 5'd7);
    @(negedge clk);
`ifdef REGISTER_FILE_BYPASS_EN
    check("x7 same-cycle p0", rd_data0, 32'h22222222);
    check("x7 same-cycle p1", rd_data1, 32'h22222222);
`else
    check("x7 same-cycle p0", rd_data0, 32'h11111111);
    check("x7 same-cycle p1", rd_data1, 32'h11111111);
`endif
    drive(1'b0, 1'b0, 5'd0, 32'h0, 5'd7, 5'd0);
    @(negedge clk);
    check("x7 next cycle", rd_data0, 32'h22222222);
    check("x0 next cycle", rd_data1, 32'h0);

    // Same-cycle write to x0 while reading x0 never forwards.
    drive(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd7);
    @(negedge clk);
    check("x0 write same-cycle p0", rd_data0, 32'h0);
    check("x7 unaffected p1", rd_data1, 32'h22222222);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
